// File: rtl/pc_fetch.sv
// pc_fetch: program counter and fetch sequencing for the single-cycle core.
//
// A Start pulse loads StartAddr and enters RUN. Each RUN cycle then advances
// the PC by one, holds it on Stall, or branches to Target. Target is either an
// absolute address or a two's-complement offset from the current PC. Halt moves
// the FSM to DONE with the PC frozen. A cycle counter reports the number of
// RUN cycles since the last Start. The counter saturates instead of wrapping.
//
// Ports:
//   Clk        in   clock; all state changes on the rising edge
//   Reset      in   synchronous active-high reset; overrides every other input
//   Start      in   load StartAddr, clear CycleCt, enter RUN (from any state)
//   StartAddr  in   PC_W  PC value loaded on Start
//   Halt       in   halt decoded at the current PC; wins over Stall and branches
//   Stall      in   hold the PC for this cycle
//   BranchAbs  in   PC <= Target (wins over BranchRel)
//   BranchRel  in   PC <= PC + Target (modulo 2^PC_W)
//   Target     in   PC_W  branch target or offset
//   ProgCtr    out  PC_W  current PC to instruction memory
//   Running    out  high while in RUN
//   Done       out  high while in DONE
//   CycleCt    out  CT_W  RUN cycles since the last Start (saturating)
module pc_fetch #(
    parameter int unsigned PC_W = 10,
    parameter int unsigned CT_W = 16
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Start,
    input  logic [PC_W-1:0] StartAddr,
    input  logic            Halt,
    input  logic            Stall,
    input  logic            BranchAbs,
    input  logic            BranchRel,
    input  logic [PC_W-1:0] Target,
    output logic [PC_W-1:0] ProgCtr,
    output logic            Running,
    output logic            Done,
    output logic [CT_W-1:0] CycleCt
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [CT_W-1:0] ct_q, ct_d;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= StIdle;
            pc_q    <= '0;
            ct_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ct_q    <= ct_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ct_d    = ct_q;

        if (Start) begin
            // A restart has the same effect in every state.
            state_d = StRun;
            pc_d    = StartAddr;
            ct_d    = '0;
        end else if (state_q == StRun) begin
            // Every non-Start RUN cycle is counted, including the Halt cycle.
            if (ct_q != {CT_W{1'b1}}) begin
                ct_d = ct_q + CT_W'(1);
            end
            if (Halt) begin
                state_d = StDone;
            end else if (Stall) begin
                pc_d = pc_q;
            end else if (BranchAbs) begin
                pc_d = Target;
            end else if (BranchRel) begin
                pc_d = pc_q + Target;
            end else begin
                pc_d = pc_q + PC_W'(1);
            end
        end
    end

    assign ProgCtr = pc_q;
    assign CycleCt = ct_q;
    assign Running = (state_q == StRun);
    assign Done    = (state_q == StDone);

endmodule

// File: tb/tb_pc_fetch.sv
module tb_pc_fetch;

    localparam int unsigned PC_W = 10;
    localparam int unsigned CT_W = 16;

    logic            clk = 1'b0;
    logic            reset, start, halt, stall, babs, brel;
    logic [PC_W-1:0] start_addr, target;

    logic [PC_W-1:0] pc;
    logic            running, done;
    logic [CT_W-1:0] ct;

    logic [PC_W-1:0] pc_s;
    logic            running_s, done_s;
    logic [3:0]      ct_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_fetch #(.PC_W(PC_W), .CT_W(CT_W)) u_dut (
        .Clk       (clk),
        .Reset     (reset),
        .Start     (start),
        .StartAddr (start_addr),
        .Halt      (halt),
        .Stall     (stall),
        .BranchAbs (babs),
        .BranchRel (brel),
        .Target    (target),
        .ProgCtr   (pc),
        .Running   (running),
        .Done      (done),
        .CycleCt   (ct)
    );

    // Narrow counter instance for the saturation check.
    pc_fetch #(.PC_W(PC_W), .CT_W(4)) u_dut_sat (
        .Clk       (clk),
        .Reset     (reset),
        .Start     (start),
        .StartAddr (start_addr),
        .Halt      (halt),
        .Stall     (stall),
        .BranchAbs (babs),
        .BranchRel (brel),
        .Target    (target),
        .ProgCtr   (pc_s),
        .Running   (running_s),
        .Done      (done_s),
        .CycleCt   (ct_s)
    );

    typedef struct {
        string           name;
        logic            reset;
        logic            start;
        logic [PC_W-1:0] start_addr;
        logic            halt;
        logic            stall;
        logic            babs;
        logic            brel;
        logic [PC_W-1:0] target;
        logic [PC_W-1:0] exp_pc;
        logic            exp_run;
        logic            exp_done;
        logic [CT_W-1:0] exp_ct;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string name, input logic r, input logic s, input logic [PC_W-1:0] sa,
                       input logic h, input logic st, input logic ba, input logic br,
                       input logic [PC_W-1:0] tg, input logic [PC_W-1:0] epc, input logic erun,
                       input logic edone, input logic [CT_W-1:0] ect);
        vec_t v;
        v.name = name; v.reset = r; v.start = s; v.start_addr = sa; v.halt = h; v.stall = st;
        v.babs = ba; v.brel = br; v.target = tg; v.exp_pc = epc; v.exp_run = erun;
        v.exp_done = edone; v.exp_ct = ect;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, input logic s, input logic [PC_W-1:0] sa, input logic h,
                         input logic st, input logic ba, input logic br,
                         input logic [PC_W-1:0] tg);
        reset = r; start = s; start_addr = sa; halt = h; stall = st; babs = ba; brel = br;
        target = tg;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        //   name        rst st addr     hlt stl abs rel tgt      pc       run dn ct
        add("rst0",      1, 0, 10'h000, 0, 0, 0, 0, 10'h000, 10'h000, 0, 0, 0);
        add("rst_start", 1, 1, 10'h055, 0, 0, 0, 0, 10'h000, 10'h000, 0, 0, 0);
        add("idle_rel",  0, 0, 10'h000, 0, 0, 0, 1, 10'h005, 10'h000, 0, 0, 0);
        add("idle_halt", 0, 0, 10'h000, 1, 0, 0, 0, 10'h000, 10'h000, 0, 0, 0);
        add("seq_start", 0, 1, 10'h010, 0, 0, 0, 0, 10'h000, 10'h010, 1, 0, 0);
        add("seq1",      0, 0, 10'h000, 0, 0, 0, 0, 10'h000, 10'h011, 1, 0, 1);
        add("seq2",      0, 0, 10'h000, 0, 0, 0, 0, 10'h000, 10'h012, 1, 0, 2);
        add("seq3",      0, 0, 10'h000, 0, 0, 0, 0, 10'h000, 10'h013, 1, 0, 3);
        add("seq4",      0, 0, 10'h000, 0, 0, 0, 0, 10'h000, 10'h014, 1, 0, 4);
        add("br_start",  0, 1, 10'h020, 0, 0, 0, 0, 10'h000, 10'h020, 1, 0, 0);
        add("rel_m1",    0, 0, 10'h000, 0, 0, 0, 1, 10'h3FF, 10'h01F, 1, 0, 1);
        add("rel_p7",    0, 0, 10'h000, 0, 0, 0, 1, 10'h007, 10'h026, 1, 0, 2);
        add("abs3",      0, 0, 10'h000, 0, 0, 1, 0, 10'h003, 10'h003, 1, 0, 3);
        add("abs_rel",   0, 0, 10'h000, 0, 0, 1, 1, 10'h001, 10'h001, 1, 0, 4);
        add("rel_zero",  0, 0, 10'h000, 0, 0, 0, 1, 10'h000, 10'h001, 1, 0, 5);
        add("stall_abs", 0, 0, 10'h000, 0, 1, 1, 0, 10'h2AA, 10'h001, 1, 0, 6);
        add("wr_start",  0, 1, 10'h3FE, 0, 0, 0, 0, 10'h000, 10'h3FE, 1, 0, 0);
        add("wr1",       0, 0, 10'h000, 0, 0, 0, 0, 10'h000, 10'h3FF, 1, 0, 1);
        add("wr_stall1", 0, 0, 10'h000, 0, 1, 0, 0, 10'h000, 10'h3FF, 1, 0, 2);
        add("wr_stall2", 0, 0, 10'h000, 0, 1, 0, 0, 10'h000, 10'h3FF, 1, 0, 3);
        add("wr_wrap",   0, 0, 10'h000, 0, 0, 0, 0, 10'h000, 10'h000, 1, 0, 4);
        add("h_start",   0, 1, 10'h003, 0, 0, 0, 0, 10'h000, 10'h003, 1, 0, 0);
        add("h1",        0, 0, 10'h000, 0, 0, 0, 0, 10'h000, 10'h004, 1, 0, 1);
        add("h2",        0, 0, 10'h000, 0, 0, 0, 0, 10'h000, 10'h005, 1, 0, 2);
        add("halt_rel",  0, 0, 10'h000, 1, 0, 0, 1, 10'h007, 10'h005, 0, 1, 3);
        add("done_hold", 0, 0, 10'h000, 0, 1, 0, 1, 10'h007, 10'h005, 0, 1, 3);
        add("restart",   0, 1, 10'h100, 0, 0, 0, 0, 10'h000, 10'h100, 1, 0, 0);
        add("halt_stl",  0, 0, 10'h000, 1, 1, 1, 0, 10'h0AA, 10'h100, 0, 1, 1);
        add("rst_done",  1, 0, 10'h000, 0, 0, 0, 0, 10'h000, 10'h000, 0, 0, 0);
        add("r_start",   0, 1, 10'h200, 0, 0, 0, 0, 10'h000, 10'h200, 1, 0, 0);
        add("r1",        0, 0, 10'h000, 0, 0, 0, 0, 10'h000, 10'h201, 1, 0, 1);
        add("rst_run",   1, 1, 10'h155, 0, 0, 0, 0, 10'h000, 10'h000, 0, 0, 0);
        add("post_rst",  0, 0, 10'h000, 0, 0, 0, 1, 10'h004, 10'h000, 0, 0, 0);

        drive(0, 0, '0, 0, 0, 0, 0, '0);
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            drive(vecs[i].reset, vecs[i].start, vecs[i].start_addr, vecs[i].halt,
                  vecs[i].stall, vecs[i].babs, vecs[i].brel, vecs[i].target);
            @(posedge clk);
            #1;
            check({vecs[i].name, ".pc"},   32'(pc),      32'(vecs[i].exp_pc));
            check({vecs[i].name, ".run"},  32'(running), 32'(vecs[i].exp_run));
            check({vecs[i].name, ".done"}, 32'(done),    32'(vecs[i].exp_done));
            check({vecs[i].name, ".ct"},   32'(ct),      32'(vecs[i].exp_ct));
        end

        // Saturation: 4-bit counter stops at 15 while the 16-bit one keeps going.
        drive(1, 0, '0, 0, 0, 0, 0, '0);
        @(posedge clk);
        #1;
        drive(0, 1, 10'h000, 0, 0, 0, 0, '0);
        @(posedge clk);
        #1;
        check("sat_start.ct", 32'(ct_s), 32'd0);
        drive(0, 0, '0, 0, 0, 0, 0, '0);
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("sat%0d.ct", i), 32'(ct_s), (i > 15) ? 32'd15 : 32'(i));
            check($sformatf("sat%0d.pc", i), 32'(pc_s), 32'(i));
        end
        check("wide_ct20", 32'(ct), 32'd20);
        check("sat_run", 32'(running_s), 32'd1);

        // Reset with Start while running returns everything to reset values.
        drive(1, 1, 10'h321, 0, 0, 0, 0, '0);
        @(posedge clk);
        #1;
        check("sat_rst.pc",   32'(pc_s),      32'd0);
        check("sat_rst.run",  32'(running_s), 32'd0);
        check("sat_rst.done", 32'(done_s),    32'd0);
        check("sat_rst.ct",   32'(ct_s),      32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
